// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out shifter with valid/ready input and per-bit valid/first output
// Outputs are registered; sout is taken straight from the shift register's leading flop.
module piso_serializer #(
  parameter int WIDTH        = 8,
  parameter int MSB_FIRST    = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shreg_next;
  logic             xfer;

  // Zero-fill while shifting so the register is empty once the last bit leaves.
  assign shreg_next = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg_q[WIDTH-1:1]};
  assign xfer = din_valid & ready_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          shreg_d   = din;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cyc_cnt_q == CYC_LAST) begin
          cyc_cnt_d = '0;
          shreg_d   = shreg_next;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (GAP_CYCLES > 0) begin
              gap_cnt_d = '0;
              state_d   = ST_GAP;
            end else if (xfer) begin
              shreg_d = din;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are derived from the next state so they line up with it.
    valid_d = (state_d == ST_SHIFT);
    first_d = (state_d == ST_SHIFT) && (bit_cnt_d == '0);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE) ||
              ((GAP_CYCLES == 0) && (state_d == ST_SHIFT) &&
               (bit_cnt_d == BIT_LAST) && (cyc_cnt_d == CYC_LAST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      gap_cnt_q <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
    end
  end

  assign din_ready  = ready_q;
  assign sout       = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
  assign sout_valid = valid_q;
  assign sout_first = first_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed table-driven bench for piso_serializer
// Four instances cover default, LSB-first, back-to-back and bit-stretch configurations.
module tb_piso_serializer;

  typedef struct packed {
    logic sout;
    logic valid;
    logic first;
    logic ready;
    logic busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din_def = '0, din_lsb = '0, din_b2b = '0, din_str = '0;
  logic       v_def = 1'b0, v_lsb = 1'b0, v_b2b = 1'b0, v_str = 1'b0;
  logic       rdy_def, so_def, sov_def, sof_def, bsy_def;
  logic       rdy_lsb, so_lsb, sov_lsb, sof_lsb, bsy_lsb;
  logic       rdy_b2b, so_b2b, sov_b2b, sof_b2b, bsy_b2b;
  logic       rdy_str, so_str, sov_str, sof_str, bsy_str;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  piso_serializer u_def (
    .clk(clk), .reset(reset), .din(din_def), .din_valid(v_def), .din_ready(rdy_def),
    .sout(so_def), .sout_valid(sov_def), .sout_first(sof_def), .busy(bsy_def));

  piso_serializer #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .din(din_lsb), .din_valid(v_lsb), .din_ready(rdy_lsb),
    .sout(so_lsb), .sout_valid(sov_lsb), .sout_first(sof_lsb), .busy(bsy_lsb));

  piso_serializer #(.GAP_CYCLES(0)) u_b2b (
    .clk(clk), .reset(reset), .din(din_b2b), .din_valid(v_b2b), .din_ready(rdy_b2b),
    .sout(so_b2b), .sout_valid(sov_b2b), .sout_first(sof_b2b), .busy(bsy_b2b));

  piso_serializer #(.CLKS_PER_BIT(3)) u_str (
    .clk(clk), .reset(reset), .din(din_str), .din_valid(v_str), .din_ready(rdy_str),
    .sout(so_str), .sout_valid(sov_str), .sout_first(sof_str), .busy(bsy_str));

  function automatic vec_t sample(int w);
    case (w)
      0:       return '{so_def, sov_def, sof_def, rdy_def, bsy_def};
      1:       return '{so_lsb, sov_lsb, sof_lsb, rdy_lsb, bsy_lsb};
      2:       return '{so_b2b, sov_b2b, sof_b2b, rdy_b2b, bsy_b2b};
      default: return '{so_str, sov_str, sof_str, rdy_str, bsy_str};
    endcase
  endfunction

  task automatic set_in(int w, logic [7:0] d, logic v);
    case (w)
      0:       begin din_def = d; v_def = v; end
      1:       begin din_lsb = d; v_lsb = v; end
      2:       begin din_b2b = d; v_b2b = v; end
      default: begin din_str = d; v_str = v; end
    endcase
  endtask

  task automatic check_vec(string tag, int idx, vec_t act, vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: sout/valid/first/ready/busy got %b expected %b", tag, idx, act, exp);
    end
  endtask

  function automatic void push(logic s, logic v, logic f, logic r, logic b);
    exp_q.push_back('{s, v, f, r, b});
  endfunction

  // Cycle 1 is the first bit, followed by one gap cycle and then idle with ready.
  function automatic void push_word(logic [7:0] seq);
    exp_q.delete();
    for (int i = 0; i < 8; i++) push(seq[7-i], 1'b1, i == 0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  task automatic start(int w, logic [7:0] d);
    @(negedge clk);
    set_in(w, d, 1'b1);
    @(posedge clk);
    #1 set_in(w, 8'h00, 1'b0);
  endtask

  task automatic run_table(int w, string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_vec(tag, i + 1, sample(w), exp_q[i]);
    end
  endtask

  localparam vec_t IDLE_V = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [15:0] b2b_bits;
    logic [7:0]  abort_bits;

    // Reset held with a pending word on every instance.
    for (int w = 0; w < 4; w++) set_in(w, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("reset", i, sample(0), IDLE_V);
    end
    for (int w = 0; w < 4; w++) set_in(w, 8'h00, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_vec("post_reset", i, sample(0), IDLE_V);
      check_vec("post_reset_b2b", i, sample(2), IDLE_V);
    end

    push_word(8'b1100_0001);
    start(0, 8'hC1);
    run_table(0, "msb_c1");

    push_word(8'b1000_0011);
    start(1, 8'hC1);
    run_table(1, "lsb_c1");

    // Back-to-back: valid held across both words.
    b2b_bits = 16'b0000_1111_1111_0000;
    exp_q.delete();
    for (int i = 0; i < 16; i++)
      push(b2b_bits[15-i], 1'b1, (i == 0) || (i == 8), (i == 7) || (i == 15), 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    set_in(2, 8'h0F, 1'b1);
    @(posedge clk);
    #1 set_in(2, 8'hF0, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_vec("b2b", i + 1, sample(2), exp_q[i]);
      if (i == 7) begin
        @(posedge clk);
        #1 set_in(2, 8'h00, 1'b0);
      end
    end

    // Stretch: each bit held for 3 cycles.
    exp_q.delete();
    for (int i = 0; i < 24; i++) push(i < 3, 1'b1, i < 3, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    start(3, 8'h80);
    run_table(3, "stretch");

    // Abort after four bits of 8'hAA.
    abort_bits = 8'b1010_1010;
    start(0, 8'hAA);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_vec("abort_pre", i + 1, sample(0), '{abort_bits[7-i], 1'b1, i == 0, 1'b0, 1'b1});
    end
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_vec("abort_async", 0, sample(0), IDLE_V);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_vec("abort_idle", i, sample(0), IDLE_V);
    end
    push_word(8'b0011_1100);
    start(0, 8'h3C);
    run_table(0, "after_abort_3c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
